// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
// Module   : debounce_bank
// Brief    : Multi-channel switch synchroniser/debouncer with edge pulses
//            and optional auto-repeat while a channel is held high.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_bank #(
    parameter int NUM_CH         = 4,
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int SYNC_STAGES    = 2,
    parameter int REPEAT_DELAY   = 0,
    parameter int REPEAT_PERIOD  = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] sw_i,
    output logic [NUM_CH-1:0] sw_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic [NUM_CH-1:0] repeat_o
);

    localparam int C_CNT_W   = $clog2(DEBOUNCE_LIMIT + 1);
    localparam int C_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int C_REP_W   = $clog2(C_REP_MAX + 1);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [C_CNT_W-1:0]     r_cnt;
        logic                   r_sw;
        logic                   r_rise;
        logic                   r_fall;
        logic                   w_s;
        logic                   w_hit;
        logic                   w_rise_nxt;
        logic                   w_fall_nxt;

        assign w_s        = r_sync[SYNC_STAGES-1];
        assign w_hit      = (w_s != r_sw) && (r_cnt == C_CNT_W'(DEBOUNCE_LIMIT - 1));
        assign w_rise_nxt = w_hit & w_s;
        assign w_fall_nxt = w_hit & ~w_s;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_sync <= '0;
                r_cnt  <= '0;
                r_sw   <= 1'b0;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], sw_i[c]};
                r_rise <= w_rise_nxt;
                r_fall <= w_fall_nxt;
                // Any agreeing sample restarts qualification from zero.
                if (w_s == r_sw) begin
                    r_cnt <= '0;
                end else if (w_hit) begin
                    r_sw  <= w_s;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + C_CNT_W'(1);
                end
            end
        end

        assign sw_o[c]   = r_sw;
        assign rise_o[c] = r_rise;
        assign fall_o[c] = r_fall;

        if (REPEAT_DELAY > 0) begin : g_rep
            logic [C_REP_W-1:0] r_rep;
            logic               r_first;
            logic               r_pulse;
            logic [C_REP_W-1:0] w_target;

            // First interval is the hold delay, later ones the repeat period.
            assign w_target = r_first ? C_REP_W'(REPEAT_DELAY - 1)
                                      : C_REP_W'(REPEAT_PERIOD - 1);

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_rep   <= '0;
                    r_first <= 1'b0;
                    r_pulse <= 1'b0;
                end else if (w_rise_nxt || w_fall_nxt || !r_sw) begin
                    r_rep   <= '0;
                    r_pulse <= 1'b0;
                    if (w_rise_nxt) begin
                        r_first <= 1'b1;
                    end
                end else if (r_rep == w_target) begin
                    r_rep   <= '0;
                    r_pulse <= 1'b1;
                    r_first <= 1'b0;
                end else begin
                    r_rep   <= r_rep + C_REP_W'(1);
                    r_pulse <= 1'b0;
                end
            end

            assign repeat_o[c] = r_pulse;
        end else begin : g_no_rep
            assign repeat_o[c] = 1'b0;
        end
    end

endmodule
`default_nettype wire
